// File: rtl/time_pkg.sv
// time_pkg: shared definitions for the elapsed-time display path.
//   BCD_W       binary width of the millisecond value
//   BCD_DIGITS  BCD digits presented to the seven-segment stage
//   BCD_MAX     largest value the six digits can show
//   bcd_state_t converter FSM states
//   bcd_digit_t one BCD digit
package time_pkg;

  localparam int          BCD_W      = 20;
  localparam int          BCD_DIGITS = 6;
  localparam int unsigned BCD_MAX    = 999999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } bcd_state_t;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble digit correction, din >= 5 ? din + 3 : din.
//   din   input BCD digit before the shift
//   dout  corrected digit
// The result of a legal double-dabble digit (0..9) never exceeds 12, so no
// carry out of the nibble exists.
module bcd_add3
  import time_pkg::*;
(
  input  bcd_digit_t din,
  output bcd_digit_t dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, W-bit binary to BCD.
// Captures t on start (or a queued request), shifts for W cycles, then
// loads the output digits and pulses valid. Digits hold between loads.
//
// Ports:
//   clk            system clock
//   KEY2           asynchronous active-low reset
//   t              binary time value in ms
//   start          conversion request, level-sampled every cycle
//   busy           conversion in progress (state != IDLE)
//   valid          one-cycle pulse when new digits are loaded
//   ones..hun_thousands  registered BCD digits
//   ovf            value at last capture exceeded 999999
//   state_dbg      current FSM state
//
// Handshake: start is a request level; any start seen while busy is
// remembered in a single pending flag and served on the first IDLE cycle,
// sampling t at that edge. valid is a single-cycle qualifier for the
// digits and ovf; there is no backpressure.
//
// Optional feature macro: BIN2BCD_SATURATE_EN. When defined, out-of-range
// results load all nines and set ovf. When undefined, the low six digits
// of the true value are loaded and ovf is tied to 0.
module bin2bcd_seq
  import time_pkg::*;
#(
  parameter int W      = BCD_W,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic         clk,
  input  logic         KEY2,
  input  logic [W-1:0] t,
  input  logic         start,
  output logic         busy,
  output logic         valid,
  output bcd_digit_t   ones,
  output bcd_digit_t   tens,
  output bcd_digit_t   hundreds,
  output bcd_digit_t   thousands,
  output bcd_digit_t   ten_thousands,
  output bcd_digit_t   hun_thousands,
  output logic         ovf,
  output bcd_state_t   state_dbg
);

  // One extra scratch digit covers the full 2^W range (7 digits for 20 bits).
  localparam int SW = 4 * (DIGITS + 1);
  localparam int CW = $clog2(W);

  bcd_state_t     state, state_n;
  logic [W-1:0]   bin_r;
  logic [SW-1:0]  scratch;
  logic [SW-1:0]  scratch_adj;
  logic [SW+W-1:0] shifted;
  logic [CW-1:0]  cnt;
  logic           pending;
  logic           valid_r;
  logic           capture;
  bcd_digit_t     dig_r  [DIGITS];
  bcd_digit_t     load_d [DIGITS];

  for (genvar g = 0; g < DIGITS + 1; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scratch[4*g +: 4]),
      .dout (scratch_adj[4*g +: 4])
    );
  end

  assign shifted = {scratch_adj, bin_r} << 1;
  assign capture = (state == IDLE) && (start || pending);

  always_ff @(posedge clk or negedge KEY2) begin
    if (!KEY2) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start || pending) state_n = SHIFT;
      SHIFT:   if (cnt == CW'(W - 1)) state_n = LOAD;
      LOAD:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge KEY2) begin
    if (!KEY2) begin
      bin_r   <= '0;
      scratch <= '0;
      cnt     <= '0;
      pending <= 1'b0;
      valid_r <= 1'b0;
      for (int i = 0; i < DIGITS; i++) dig_r[i] <= '0;
    end else begin
      valid_r <= 1'b0;
      if (capture) begin
        bin_r   <= t;
        scratch <= '0;
        cnt     <= '0;
        pending <= 1'b0;
      end else if (state != IDLE && start) begin
        pending <= 1'b1;
      end
      if (state == SHIFT) begin
        scratch <= shifted[SW+W-1:W];
        bin_r   <= shifted[W-1:0];
        cnt     <= cnt + 1'b1;
      end
      if (state == LOAD) begin
        for (int i = 0; i < DIGITS; i++) dig_r[i] <= load_d[i];
        valid_r <= 1'b1;
      end
    end
  end

`ifdef BIN2BCD_SATURATE_EN
  logic over;

  // Above 999999 either the top scratch digit is set or a low digit is
  // not a legal BCD code.
  always_comb begin
    over = (scratch[SW-1 -: 4] != 4'd0);
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] > 4'd9) over = 1'b1;
    end
    for (int i = 0; i < DIGITS; i++) begin
      load_d[i] = over ? 4'd9 : scratch[4*i +: 4];
    end
  end

  logic ovf_r;
  always_ff @(posedge clk or negedge KEY2) begin
    if (!KEY2)               ovf_r <= 1'b0;
    else if (state == LOAD)  ovf_r <= over;
  end
  assign ovf = ovf_r;
`else
  always_comb begin
    for (int i = 0; i < DIGITS; i++) load_d[i] = scratch[4*i +: 4];
  end
  assign ovf = 1'b0;
`endif

  assign busy          = (state != IDLE);
  assign valid         = valid_r;
  assign state_dbg     = state;
  assign ones          = dig_r[0];
  assign tens          = dig_r[1];
  assign hundreds      = dig_r[2];
  assign thousands     = dig_r[3];
  assign ten_thousands = dig_r[4];
  assign hun_thousands = dig_r[5];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed scoreboard bench for bin2bcd_seq.
// Expected entries are {ovf, six BCD digits} plus the cycle number at which
// valid must be seen; a monitor pops them whenever valid is high.
module tb_bin2bcd_seq;
  import time_pkg::*;

  localparam int W = 20;

  // clock / reset
  logic clk = 1'b0;
  logic KEY2 = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [W-1:0] t = '0;
  logic         start = 1'b0;
  logic         busy, valid, ovf;
  bcd_digit_t   ones, tens, hundreds, thousands, ten_thousands, hun_thousands;
  bcd_state_t   state_dbg;

  bin2bcd_seq dut (
    .clk           (clk),
    .KEY2          (KEY2),
    .t             (t),
    .start         (start),
    .busy          (busy),
    .valid         (valid),
    .ones          (ones),
    .tens          (tens),
    .hundreds      (hundreds),
    .thousands     (thousands),
    .ten_thousands (ten_thousands),
    .hun_thousands (hun_thousands),
    .ovf           (ovf),
    .state_dbg     (state_dbg)
  );

  int total = 0;
  int bad   = 0;

  logic [24:0] exp_q[$];
  int          exp_cyc_q[$];

  function automatic logic [23:0] cur_digits();
    return {hun_thousands, ten_thousands, thousands, hundreds, tens, ones};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // scoreboard monitor
  logic [23:0] held = '0;
  always @(negedge clk) begin
    logic [24:0] e;
    int          ec;
    if (!KEY2) begin
      held = cur_digits();
    end else if (valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL stray_valid: got digits %06h with no conversion outstanding", cur_digits());
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("result", {7'd0, ovf, cur_digits()}, {7'd0, e});
        check("latency", cyc, ec);
      end
      held = cur_digits();
    end else begin
      check("hold", {8'd0, cur_digits()}, {8'd0, held});
    end
  end

  // driver tasks
  task automatic wait_done(input int bound);
    bit done = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      t = W'($urandom_range(0, 1048575));
      if (!busy && exp_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL timeout: conversion not finished within %0d cycles", bound);
    end
  endtask

  task automatic convert(input logic [W-1:0] val, input logic [24:0] exp, input bit chk_busy);
    @(negedge clk);
    t     = val;
    start = 1'b1;
    exp_q.push_back(exp);
    exp_cyc_q.push_back(cyc + 22);
    @(negedge clk);
    start = 1'b0;
    if (chk_busy) begin
      // now after E0: busy for E0..E20, low after E21
      for (int j = 1; j <= 21; j++) begin
        check("busy_high", {31'd0, busy}, 32'd1);
        t = W'($urandom_range(0, 1048575));
        @(negedge clk);
      end
      check("busy_low", {31'd0, busy}, 32'd0);
    end
    wait_done(60);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_digits", {8'd0, cur_digits()}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    KEY2 = 1'b1;
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_state", {30'd0, state_dbg}, {30'd0, IDLE});

    // directed conversions
    convert(20'd0,      25'h0000000, 1'b1);
    convert(20'd123456, 25'h0123456, 1'b0);
    convert(20'd999999, 25'h0999999, 1'b0);
    convert(20'd1,      25'h0000001, 1'b0);
    convert(20'd900009, 25'h0900009, 1'b0);
`ifdef BIN2BCD_SATURATE_EN
    convert(20'd1048575, 25'h1999999, 1'b0);
`else
    convert(20'd1048575, 25'h0048575, 1'b0);
`endif

    // repeated requests while busy collapse into one, sampling the latest t
    @(negedge clk);
    t     = 20'd100;
    start = 1'b1;
    exp_q.push_back(25'h0000100);
    exp_cyc_q.push_back(cyc + 22);
    exp_q.push_back(25'h0000200);
    exp_cyc_q.push_back(cyc + 44);
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      start = (j == 5 || j == 10);
      if (j == 15) t = 20'd200;
    end
    start = 1'b0;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    check("pend_drained", exp_q.size(), 32'd0);
    repeat (3) @(negedge clk);
    check("pend_no_extra", {31'd0, busy}, 32'd0);

    // reset in the middle of a conversion of 555555
    @(negedge clk);
    t     = 20'd555555;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_busy_before", {31'd0, busy}, 32'd1);
    KEY2 = 1'b0;
    #1;
    check("mid_rst_digits", {8'd0, cur_digits()}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_valid", {31'd0, valid}, 32'd0);
    repeat (3) @(negedge clk);
    KEY2 = 1'b1;
    repeat (25) @(negedge clk);
    check("mid_no_valid", {31'd0, busy}, 32'd0);
    convert(20'd654321, 25'h0654321, 1'b0);

    repeat (2) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential double-dabble converter between the millisecond timer and the seven-segment control stage. It captures the 20-bit elapsed-time value `t` on a start strobe and converts it to six BCD digits over 20 shift cycles. It holds the digits stable until the next conversion completes, so the display never sees a half-converted value. This multi-cycle datapath replaces wide combinational divide/modulo logic.

## Interface
Parameters:
- `W`, 20: binary input width.
- `DIGITS`, 6: BCD digits presented at the outputs. The internal register holds `DIGITS+1` digits to cover the full 20-bit range.

Ports:
- `clk`  in  1  system clock.
- `KEY2`  in  1  reset, asynchronous, active-low.
- `t`  in  W  binary time value in ms from the timer stage.
- `start`  in  1  conversion request, level-sampled each cycle. Normally wired to the 1 ms tick `time_1ms`.
- `busy`  out  1  conversion in progress.
- `valid`  out  1  one-cycle pulse when new digits are loaded.
- `ones`, `tens`, `hundreds`, `thousands`, `ten_thousands`, `hun_thousands`  out  4 each  BCD digits, registered and held.
- `ovf`  out  1  `t` at last capture exceeded 999999.

## Operation
- States (`bcd_state_t`): IDLE, SHIFT, LOAD.
- IDLE:
  - `start`=1 or `pending`=1 → capture `t` into `bin_r`, clear the scratch BCD register (28 b), set `cnt`=0, clear `pending`, go to SHIFT.
- SHIFT, one iteration per cycle:
  - Every scratch digit ≥5 gets +3.
  - Then {scratch, `bin_r`} shifts left by 1 and `cnt` increments.
  - After 20 iterations (`cnt`=W-1 processed) → LOAD.
- LOAD:
  - Output digits are written from the scratch register and `ovf` is set per the Configuration section.
  - `valid`=1 for this cycle; go to IDLE.
- `start`=1 while in SHIFT or LOAD sets `pending`. Multiple requests collapse into one.
- A pending conversion launches on the first IDLE cycle and samples `t` at that edge, i.e. the freshest value.
- `busy` = (state != IDLE).
- Arithmetic is unsigned. The add-3 is applied to the 4-bit digit with no carry-out between digits; none is possible in double-dabble.

## Timing
- Reset (`KEY2`=0, asynchronous):
  - State IDLE; `pending`, `busy`, `valid`, `ovf` = 0; all digits = 0; scratch registers cleared.
  - Takes effect immediately, including mid-conversion. The aborted conversion produces no `valid`.
- Reset release: first active edge with `start`=1 begins a conversion.
- Latency, with `start` sampled at edge E0:
  - Shifts occur at E1..E20; state is LOAD after E20.
  - Digits update and `valid` pulses after E21; `busy` is high from E0+ until E21.
  - Total: 21 cycles from capture to valid output.
- Back-to-back conversions: a pending request captures at E22, so the minimum period is 22 cycles. This is far below 1 ms at 50 MHz.
- Outputs change only at LOAD, so digits are glitch-free between `valid` pulses.

## Configuration
- `BIN2BCD_SATURATE_EN` defined:
  - If the converted value exceeds 999999 (the 7th digit is nonzero, or the low six digits are out of range), all six digits load 9 and `ovf`=1.
  - Otherwise `ovf`=0.
- Not defined:
  - Digits load the low six BCD digits of the true value (1048575 → 0,4,8,5,7,5 from `hun_thousands` down).
  - `ovf` is driven 0 constantly; the overflow compare logic is not synthesized.

## Structure
- `time_pkg` holds:
  - `BCD_W` = 20, `BCD_DIGITS` = 6, `BCD_MAX` = 999999.
  - typedef `bcd_state_t` (IDLE, SHIFT, LOAD).
  - typedef `bcd_digit_t` (logic [3:0]).
- One sub-module, `bcd_add3`: combinational 4-bit correction (in ≥5 ? in+3 : in). It is instantiated `DIGITS+1` times in a generate loop.
- Counter, FSM, pending flag and output registers live in `bin2bcd_seq`.

## Test plan
- Reset then `t`=0, `start` pulse → `valid` exactly 21 cycles later; all digits 0; `ovf`=0; `busy` high for 21 cycles.
- `t`=123456 → digits 1,2,3,4,5,6; `t`=999999 → all 9, `ovf`=0.
- `t`=1048575:
  - with `BIN2BCD_SATURATE_EN`, all 9 and `ovf`=1;
  - without it, 0,4,8,5,7,5 and `ovf`=0.
- `start` at E0 (`t`=100), `start` again at E5 and E10, `t` changed to 200 at E15:
  - first `valid` shows 000100;
  - exactly one further conversion captures at E22 and shows 000200 at E43.
- Assert `KEY2` low at E10 of a conversion of 555555 → outputs 0 asynchronously and no `valid`. After release, a new `start` converts correctly.
- Digits held constant between `valid` pulses while `t` changes every cycle (checked with a monitor assertion).
